// File: rtl/sao_lcu_filter_if.sv
// Pixel-in / SRAM-write bus of the SAO LCU engine.
// din transfers on a rising edge only when in_en=1 and busy=0; sram_* is a write-only strobe bus.
interface sao_lcu_filter_if #(
    parameter int PIX_W  = 8,
    parameter int OFF_W  = 4,
    parameter int LCU_XW = 3,
    parameter int ADDR_W = 14
);
    logic                   in_en;
    logic [PIX_W-1:0]       din;
    logic [1:0]             sao_type;
    logic [4:0]             sao_band_pos;
    logic [1:0]             sao_eo_class;
    logic [4*OFF_W-1:0]     sao_offset;
    logic [LCU_XW-1:0]      lcu_x;
    logic [LCU_XW-1:0]      lcu_y;
    logic [1:0]             lcu_size;
    logic                   busy;
    logic                   finish;
    logic                   sram_we;
    logic [ADDR_W-1:0]      sram_addr;
    logic [PIX_W-1:0]       sram_wdata;

    modport master (
        output in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size,
        input  busy, finish, sram_we, sram_addr, sram_wdata
    );
    modport slave (
        input  in_en, din, sao_type, sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size,
        output busy, finish, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sao_lcu_filter.sv
// SAO engine: buffers one LCU in raster order, then writes band- or edge-offset filtered
// pixels to the frame SRAM one per cycle.
module sao_lcu_filter #(
    parameter int PIX_W   = 8,
    parameter int OFF_W   = 4,
    parameter int IMG_W   = 128,
    parameter int LCU_MAX = 64,
    parameter int LCU_XW  = 3,
    parameter int ADDR_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    sao_lcu_filter_if.slave   bus,
    output logic [2:0]        o_dbg_state
);
    localparam int RW = $clog2(LCU_MAX);
    localparam int IW = 2 * RW;
    localparam logic [RW-1:0] R_ONE = RW'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PROC, S_FLUSH, S_DONE} state_t;
    state_t r_state, w_next;

    logic [PIX_W-1:0]   r_buf [LCU_MAX*LCU_MAX];
    logic [1:0]         r_type, r_eo, r_size;
    logic [4:0]         r_band;
    logic [4*OFF_W-1:0] r_off;
    logic [LCU_XW-1:0]  r_lcu_x, r_lcu_y;
    logic [RW-1:0]      r_row, r_col;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [PIX_W-1:0]   r_wdata;

    logic               w_busy, w_accept, w_first, w_last_pix, w_last_lcu;
    logic [2:0]         w_sh;
    logic [RW-1:0]      w_nm1, w_ar, w_ac, w_br, w_bc;
    logic               w_border, w_apply;
    logic [IW-1:0]      w_idx, w_idx_a, w_idx_b;
    logic [PIX_W-1:0]   w_c, w_a, w_b, w_clip, w_out;
    logic [2:0]         w_s;
    logic [4:0]         w_k5;
    logic [1:0]         w_k;
    logic [OFF_W-1:0]   w_off_sel;
    logic signed [PIX_W+1:0] w_sum;
    logic [ADDR_W-1:0]  w_xpix, w_ypix, w_addr;

    always_comb begin
        case (r_size)
            2'd0:    w_sh = 3'd4;
            2'd1:    w_sh = 3'd5;
            default: w_sh = 3'd6;
        endcase
    end

    assign w_nm1      = RW'((32'd1 << w_sh) - 32'd1);
    assign w_busy     = (r_state == S_PROC) || (r_state == S_FLUSH);
    assign w_accept   = bus.in_en && !w_busy;
    assign w_first    = w_accept && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_pix = (r_row == w_nm1) && (r_col == w_nm1);
    assign w_last_lcu = (((32'(r_lcu_x) + 32'd1) << w_sh) == 32'(IMG_W)) &&
                        (((32'(r_lcu_y) + 32'd1) << w_sh) == 32'(IMG_W));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_next = w_accept ? S_LOAD : S_IDLE;
            S_LOAD:         if (w_accept && w_last_pix) w_next = S_PROC;
            S_PROC:         if (w_last_pix) w_next = S_FLUSH;
            S_FLUSH:        w_next = w_last_lcu ? S_DONE : S_IDLE;
            default:        w_next = S_IDLE;
        endcase
    end

    // Neighbour coordinates wrap harmlessly on the border; those pixels bypass the offset anyway.
    always_comb begin
        w_ar = r_row;
        w_ac = r_col;
        w_br = r_row;
        w_bc = r_col;
        w_border = 1'b0;
        case (r_eo)
            2'd0: begin
                w_ac = r_col - R_ONE; w_bc = r_col + R_ONE;
                w_border = (r_col == '0) || (r_col == w_nm1);
            end
            2'd1: begin
                w_ar = r_row - R_ONE; w_br = r_row + R_ONE;
                w_border = (r_row == '0) || (r_row == w_nm1);
            end
            2'd2: begin
                w_ar = r_row - R_ONE; w_ac = r_col - R_ONE;
                w_br = r_row + R_ONE; w_bc = r_col + R_ONE;
                w_border = (r_row == '0) || (r_row == w_nm1) || (r_col == '0) || (r_col == w_nm1);
            end
            default: begin
                w_ar = r_row - R_ONE; w_ac = r_col + R_ONE;
                w_br = r_row + R_ONE; w_bc = r_col - R_ONE;
                w_border = (r_row == '0) || (r_row == w_nm1) || (r_col == '0) || (r_col == w_nm1);
            end
        endcase
    end

    assign w_idx   = (IW'(r_row) << w_sh) | IW'(r_col);
    assign w_idx_a = (IW'(w_ar) << w_sh) | IW'(w_ac);
    assign w_idx_b = (IW'(w_br) << w_sh) | IW'(w_bc);
    assign w_c     = r_buf[w_idx];
    assign w_a     = r_buf[w_idx_a];
    assign w_b     = r_buf[w_idx_b];
    assign w_k5    = w_c[PIX_W-1 -: 5] - r_band;

    always_comb begin
        w_s = 3'd0;
        if (w_c > w_a) w_s = w_s + 3'd1;
        else if (w_c < w_a) w_s = w_s - 3'd1;
        if (w_c > w_b) w_s = w_s + 3'd1;
        else if (w_c < w_b) w_s = w_s - 3'd1;
        w_apply = 1'b0;
        w_k = 2'd0;
        if (r_type == 2'd1) begin
            w_apply = (w_k5 < 5'd4);
            w_k = w_k5[1:0];
        end else if (r_type == 2'd2 && !w_border) begin
            w_apply = 1'b1;
            case (w_s)
                3'b110:  w_k = 2'd0;
                3'b111:  w_k = 2'd1;
                3'b001:  w_k = 2'd2;
                3'b010:  w_k = 2'd3;
                default: w_apply = 1'b0;
            endcase
        end
        w_off_sel = r_off[w_k*OFF_W +: OFF_W];
        w_sum = $signed({2'b00, w_c}) +
                $signed({{(PIX_W+2-OFF_W){w_off_sel[OFF_W-1]}}, w_off_sel});
        if (w_sum[PIX_W+1])  w_clip = '0;
        else if (w_sum[PIX_W]) w_clip = '1;
        else                 w_clip = w_sum[PIX_W-1:0];
        w_out = w_apply ? w_clip : w_c;
    end

    assign w_xpix = (ADDR_W'(r_lcu_x) << w_sh) + ADDR_W'(r_col);
    assign w_ypix = (ADDR_W'(r_lcu_y) << w_sh) + ADDR_W'(r_row);
    assign w_addr = w_ypix * ADDR_W'(IMG_W) + w_xpix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_type  <= '0;
            r_eo    <= '0;
            r_size  <= '0;
            r_band  <= '0;
            r_off   <= '0;
            r_lcu_x <= '0;
            r_lcu_y <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            if (w_first) begin
                r_type  <= bus.sao_type;
                r_eo    <= bus.sao_eo_class;
                r_size  <= bus.lcu_size;
                r_band  <= bus.sao_band_pos;
                r_off   <= bus.sao_offset;
                r_lcu_x <= bus.lcu_x;
                r_lcu_y <= bus.lcu_y;
            end
            if (w_accept || r_state == S_PROC) begin
                if (w_last_pix) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (r_col == w_nm1) begin
                    r_col <= '0;
                    r_row <= r_row + R_ONE;
                end else begin
                    r_col <= r_col + R_ONE;
                end
            end
            if (r_state == S_PROC) begin
                r_we    <= 1'b1;
                r_addr  <= w_addr;
                r_wdata <= w_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_buf[w_idx] <= bus.din;
    end

    assign bus.busy       = w_busy;
    assign bus.finish     = (r_state == S_DONE);
    assign bus.sram_we    = r_we;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_wdata = r_wdata;
    assign o_dbg_state    = r_state;
endmodule
